// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file sequencer.
// Opcodes, FSM states and the write-back decode live here.
package regfile_seq_pkg;

   localparam int DW = 16;
   localparam int AW = 3;
   localparam int IW = 8;

   typedef enum logic [2:0] {
      MOVI = 3'b000,
      MOV  = 3'b001,
      ADD  = 3'b010,
      SUB  = 3'b011,
      AND  = 3'b100,
      MVN  = 3'b101,
      CMP  = 3'b110,
      RSVD = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_B,
      EXEC,
      WB
   } state_e;

   function automatic logic writes_back(op_e op);
      return !(op == CMP || op == RSVD);
   endfunction

   function automatic logic updates_flags(op_e op);
      return op == ADD || op == SUB || op == CMP;
   endfunction

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational ALU for the register-file sequencer.
// Produces the result word and its Z/N/V flags.
module regfile_seq_alu
   import regfile_seq_pkg::*;
(
   input  op_e           op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] imm_x,
   output logic [DW-1:0] r,
   output logic          z,
   output logic          n,
   output logic          v
);

   always_comb begin
      r = '0;
      v = 1'b0;
      case (op)
         MOVI: r = imm_x;
         MOV:  r = a;
         ADD: begin
            r = a + b;
            v = (a[DW-1] == b[DW-1]) &&
                (r[DW-1] != a[DW-1]);
         end
         SUB, CMP: begin
            r = a - b;
            v = (a[DW-1] != b[DW-1]) &&
                (r[DW-1] != a[DW-1]);
         end
         AND:  r = a & b;
         MVN:  r = ~a;
         default: r = '0;
      endcase
      z = (r == '0);
      n = r[DW-1];
   end

endmodule

// File: rtl/regfile_sequencer.sv
// Sequences the 8x16 register file through read A, read B,
// execute and write-back for one command per handshake.
module regfile_sequencer
   import regfile_seq_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [AW-1:0] cmd_rd,
   input  logic [AW-1:0] cmd_rs,
   input  logic [AW-1:0] cmd_rt,
   input  logic [IW-1:0] cmd_imm,
   output logic [AW-1:0] rf_readnum,
   input  logic [DW-1:0] rf_data_out,
   output logic [AW-1:0] rf_writenum,
   output logic          rf_write,
   output logic [DW-1:0] rf_data_in,
   output logic          done,
   output logic [DW-1:0] result,
   output logic          flag_z,
   output logic          flag_n,
   output logic          flag_v,
   output logic          err
);

   state_e        state;
   state_e        state_nx;
   op_e           op_q;
   logic [AW-1:0] rd_q;
   logic [AW-1:0] rt_q;
   logic [IW-1:0] imm_q;
   logic [DW-1:0] a_q;
   logic [DW-1:0] b_q;
   logic [DW-1:0] imm_x;
   logic [DW-1:0] alu_r;
   logic          alu_z;
   logic          alu_n;
   logic          alu_v;

   assign imm_x = {{(DW-IW){imm_q[IW-1]}}, imm_q};

   regfile_seq_alu u_alu (
      .op    (op_q),
      .a     (a_q),
      .b     (b_q),
      .imm_x (imm_x),
      .r     (alu_r),
      .z     (alu_z),
      .n     (alu_n),
      .v     (alu_v)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      cmd_ready   = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      rf_write    = 1'b0;
      rf_writenum = rd_q;
      rf_data_in  = result;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nx = RD_A;
         end
         RD_A: state_nx = RD_B;
         RD_B: state_nx = EXEC;
         EXEC: state_nx = WB;
         WB: begin
            done     = 1'b1;
            err      = (op_q == RSVD);
            rf_write = writes_back(op_q);
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Read index is registered so it is stable for the whole read cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= MOVI;
         rd_q       <= '0;
         rt_q       <= '0;
         imm_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         rf_readnum <= '0;
         result     <= '0;
         flag_z     <= 1'b0;
         flag_n     <= 1'b0;
         flag_v     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  op_q       <= op_e'(cmd_op);
                  rd_q       <= cmd_rd;
                  rt_q       <= cmd_rt;
                  imm_q      <= cmd_imm;
                  rf_readnum <= cmd_rs;
               end
            end
            RD_A: begin
               a_q        <= rf_data_out;
               rf_readnum <= rt_q;
            end
            RD_B: b_q <= rf_data_out;
            EXEC: begin
               result <= alu_r;
               if (updates_flags(op_q)) begin
                  flag_z <= alu_z;
                  flag_n <= alu_n;
                  flag_v <= alu_v;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
